// File: rtl/program_sequencer.sv
// Fetch/issue controller: walks the PC from 0 to LAST_ADDR, latches each instruction
// word and issues its decoded fields to the datapath one at a time with a valid/done handshake.
module program_sequencer #(
  parameter logic [7:0] LAST_ADDR = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] instr,
  input  logic       exec_done,
  output logic [7:0] pc,
  output logic [2:0] opcode,
  output logic [1:0] rd,
  output logic [1:0] rs1,
  output logic [1:0] rs2,
  output logic       issue_valid,
  output logic       busy,
  output logic       halted,
  output logic [8:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [8:0] ir_r;
  logic [7:0] pc_r;
  logic [8:0] retired_r;
  logic       issue_valid_r;
  logic       busy_r;
  logic       halted_r;
  logic       retire_s;
  logic       restart_s;

  // Next-state decode plus the retire and (re)start qualifiers
  always_comb begin
    state_s   = state_r;
    retire_s  = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s   = S_FETCH;
          restart_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_ISSUE;
      S_ISSUE: state_s = S_WAIT;
      S_WAIT: begin
        if (exec_done) begin
          retire_s = 1'b1;
          if (pc_r == LAST_ADDR) begin
            state_s = S_HALT;
          end else begin
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HALT: begin
        if (start) begin
          state_s   = S_FETCH;
          restart_s = 1'b1;
        end else begin
          state_s = S_HALT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, PC, instruction register, retire counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      pc_r          <= 8'd0;
      ir_r          <= 9'd0;
      retired_r     <= 9'd0;
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      // The PC stops at LAST_ADDR rather than wrapping, so 255 never rolls back to 0
      if (restart_s || (state_s == S_IDLE)) begin
        pc_r <= 8'd0;
      end else if (retire_s && (pc_r != LAST_ADDR)) begin
        pc_r <= pc_r + 8'd1;
      end else begin
        pc_r <= pc_r;
      end
      if (state_r == S_FETCH) begin
        ir_r <= instr;
      end else begin
        ir_r <= ir_r;
      end
      if (restart_s) begin
        retired_r <= 9'd0;
      end else if (retire_s) begin
        retired_r <= retired_r + 9'd1;
      end else begin
        retired_r <= retired_r;
      end
      issue_valid_r <= (state_s == S_ISSUE);
      busy_r        <= (state_s == S_FETCH) || (state_s == S_ISSUE) || (state_s == S_WAIT);
      halted_r      <= (state_s == S_HALT);
    end
  end

  assign pc          = pc_r;
  assign opcode      = ir_r[8:6];
  assign rd          = ir_r[5:4];
  assign rs1         = ir_r[3:2];
  assign rs2         = ir_r[1:0];
  assign issue_valid = issue_valid_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign retired     = retired_r;

endmodule
